// File: rtl/tdr_capture_packer.sv
// -----------------------------------------------------------------------------
// tdr_capture_packer
//
// Captures the digital comparator wave of the TDR front end. The raw wave is
// synchronised, an armed trigger condition starts a record, samples are
// decimated and packed MSB-first (oldest sample in the MSB) into WORD_W-bit
// words, and a fixed-length record of REC_WORDS words is buffered in a
// show-ahead FIFO that drains through a valid/ready handshake.
//
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset, overrides every other input
//   wave_in     raw comparator wave, asynchronous to clk
//   arm         one-cycle pulse, starts a record when idle
//   abort       one-cycle pulse, cancels the record and flushes the FIFO
//   trig_mode   00/11 immediate, 01 rising edge, 10 falling edge
//   decim       one sample is taken every decim+1 clocks
//   data_out    FIFO head word (zero when the FIFO is empty)
//   data_valid  data_out holds a valid word
//   data_ready  consumer accepts the head word
//   busy        a record is armed, capturing or draining
//   done        one-cycle pulse when a record has fully drained
//   overflow    sticky flag, at least one word of the record was dropped
// -----------------------------------------------------------------------------
module tdr_capture_packer #(
  parameter int WORD_W     = 8,
  parameter int DECIM_W    = 8,
  parameter int REC_WORDS  = 64,
  parameter int FIFO_DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wave_in,
  input  logic               arm,
  input  logic               abort,
  input  logic [1:0]         trig_mode,
  input  logic [DECIM_W-1:0] decim,
  output logic [WORD_W-1:0]  data_out,
  output logic               data_valid,
  input  logic               data_ready,
  output logic               busy,
  output logic               done,
  output logic               overflow
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int BW  = $clog2(WORD_W);
  localparam int WCW = (REC_WORDS > 1) ? $clog2(REC_WORDS) : 1;

  localparam logic [BW-1:0]  LAST_BIT  = BW'(WORD_W - 1);
  localparam logic [WCW-1:0] LAST_WORD = WCW'(REC_WORDS - 1);
  localparam logic [AW:0]    FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DRAIN   = 2'd3;

  // ---------------------------------------------------------------------------
  // Synchroniser and edge detection
  // ---------------------------------------------------------------------------
  logic sync1_q, wave_s_q, wave_p_q;
  logic rise, fall;

  // NOTE: every clocked block uses non-blocking assignments so all flops
  // update from the same pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      wave_s_q <= 1'b0;
      wave_p_q <= 1'b0;
    end else begin
      sync1_q  <= wave_in;
      wave_s_q <= sync1_q;
      wave_p_q <= wave_s_q;
    end
  end

  assign rise = wave_s_q & ~wave_p_q;
  assign fall = ~wave_s_q & wave_p_q;

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  logic [1:0]         state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [DECIM_W-1:0] decim_q, decim_d;
  logic [DECIM_W-1:0] dec_cnt_q, dec_cnt_d;
  logic [BW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [WORD_W-2:0]  shift_q, shift_d;
  logic [WCW-1:0]     word_cnt_q, word_cnt_d;
  logic               done_q, done_d;
  logic               overflow_q;

  logic [WORD_W-1:0]  push_word;
  logic               trig, run, push_req, flush, ovf_clr;
  logic [AW:0]        fifo_cnt_q;

  // The word that would be pushed if this sample completes it.
  assign push_word = {shift_q, wave_s_q};

  always_comb begin
    case (mode_q)
      2'b01:   trig = rise;
      2'b10:   trig = fall;
      default: trig = 1'b1;
    endcase
  end

  // NOTE: every signal driven here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    decim_d    = decim_q;
    dec_cnt_d  = dec_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    word_cnt_d = word_cnt_q;
    done_d     = 1'b0;
    run        = 1'b0;
    push_req   = 1'b0;
    flush      = 1'b0;
    ovf_clr    = 1'b0;

    if (abort) begin
      // Abort beats arm and any sample due this cycle; partial word is lost.
      flush      = 1'b1;
      ovf_clr    = 1'b1;
      state_d    = ST_IDLE;
      dec_cnt_d  = '0;
      bit_cnt_d  = '0;
      shift_d    = '0;
      word_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arm) begin
            state_d    = ST_ARMED;
            mode_d     = trig_mode;
            decim_d    = decim;
            ovf_clr    = 1'b1;
            dec_cnt_d  = '0;
            bit_cnt_d  = '0;
            shift_d    = '0;
            word_cnt_d = '0;
          end
        end
        ST_ARMED: begin
          // The trigger cycle is itself the first sample slot.
          if (trig) begin
            state_d = ST_CAPTURE;
            run     = 1'b1;
          end
        end
        ST_CAPTURE: run = 1'b1;
        default: begin
          if (fifo_cnt_q == '0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      endcase

      if (run) begin
        dec_cnt_d = (dec_cnt_q == decim_q) ? '0 : dec_cnt_q + 1'b1;
        if (dec_cnt_q == '0) begin
          if (bit_cnt_q == LAST_BIT) begin
            push_req   = 1'b1;
            bit_cnt_d  = '0;
            shift_d    = '0;
            // Dropped words still count toward the record length.
            word_cnt_d = word_cnt_q + 1'b1;
            if (word_cnt_q == LAST_WORD) begin
              state_d    = ST_DRAIN;
              word_cnt_d = '0;
            end
          end else begin
            shift_d   = push_word[WORD_W-2:0];
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mode_q     <= 2'b00;
      decim_q    <= '0;
      dec_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      word_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      decim_q    <= decim_d;
      dec_cnt_q  <= dec_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      word_cnt_q <= word_cnt_d;
      done_q     <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Show-ahead FIFO
  // ---------------------------------------------------------------------------
  logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic              full, pop, push_ok, drop;

  assign full    = (fifo_cnt_q == FULL_CNT);
  assign pop     = data_valid & data_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_ok = push_req & (~full | pop);
  assign drop    = push_req & full & ~pop;

  // NOTE: the storage array has no reset; empty entries are never observable
  // because data_out is forced to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || ovf_clr) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end
  end

  assign data_valid = (fifo_cnt_q != '0);
  assign data_out   = data_valid ? mem_q[rd_ptr_q] : '0;
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign overflow   = overflow_q;

endmodule
